// File: rtl/cache_responder_pkg.sv
// Shared types and constants for the cache_responder block.
// State encoding, request-op encoding and the latched-request record
// used by the responder FSM.
package cache_responder_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  // Responder FSM states; encodings are fixed so traces match the protocol docs.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Request captured on acceptance; the word address drops the always-zero bit 0.
  typedef struct packed {
    logic [ADDR_W-2:0] waddr;
    logic [DATA_W-1:0] data;
    op_t               op;
    logic              hit;
  } req_t;

endpackage

// File: rtl/cache_responder_resp_backing_store.sv
// resp_backing_store: word-addressed backing memory behind the responder.
// Synchronous write and combinational read. The createdump request is
// accepted on the interface and has no effect on storage or timing.
module resp_backing_store
  import cache_responder_pkg::*;
#(
  parameter int MEM_ID = 0,
  parameter int MEM_AW = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              createdump,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**MEM_AW];

  // Write port.
  // NOTE: storage arrays carry no reset; clearing them would need a per-word
  // reset tree, and their contents survive reset by design.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cache_responder.sv
// cache_responder: responder end of the stalling memory protocol.
// Direct-mapped, one word per line, write-through, no-write-allocate cache in
// front of a fixed-latency backing store. Read hits complete in the request
// cycle; misses and all writes stall for LATENCY cycles, then Done for one cycle.
// Build option: define CACHE_RESP_EN to include the tag/data arrays; without it
// every read takes the stall path and CacheHit is tied low.
module cache_responder
  import cache_responder_pkg::*;
#(
  parameter int MEM_ID  = 0,
  parameter int LINES   = 16,
  parameter int LATENCY = 4,
  parameter int MEM_AW  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  input  logic              createdump,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              err
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t            state;
  req_t              req;
  logic [CNT_W-1:0]  cnt;
  logic              stall_q;
  logic              done_q;

  logic              bad_req;
  logic              lookup_hit;
  logic              rd_hit;
  logic              accept;
  logic [DATA_W-1:0] line_data;
  logic [DATA_W-1:0] store_rdata;
  logic              store_we;

  // Malformed requests are only judged in IDLE; WAIT and DONE ignore the bus.
  assign bad_req = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
  assign rd_hit  = (state == IDLE) & Rd & ~bad_req & lookup_hit;
  assign accept  = (state == IDLE) & (Rd | Wr) & ~bad_req & ~rd_hit;

`ifdef CACHE_RESP_EN
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 1;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] lines [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  assign idx        = Addr[IDX_W:1];
  assign tag        = Addr[ADDR_W-1:IDX_W+1];
  assign req_idx    = req.waddr[IDX_W-1:0];
  assign req_tag    = req.waddr[ADDR_W-2:IDX_W];
  assign lookup_hit = valid[idx] && (tags[idx] == tag);
  assign line_data  = lines[idx];

  // Valid bits: cleared by reset, set when a read miss installs its line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (done_q && req.op == OP_RD) begin
      valid[req_idx] <= 1'b1;
    end
  end

  // Tag/data update in DONE: install on read, write-through only on a write hit.
  always_ff @(posedge clk) begin
    if (done_q) begin
      if (req.op == OP_RD) begin
        tags[req_idx]  <= req_tag;
        lines[req_idx] <= store_rdata;
      end else if (req.hit) begin
        lines[req_idx] <= req.data;
      end
    end
  end
`else
  assign lookup_hit = 1'b0;
  assign line_data  = '0;
`endif

  // Responder FSM with counter and registered Stall/Done-for-miss flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req     <= '0;
      cnt     <= '0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req.waddr <= Addr[ADDR_W-1:1];
            req.data  <= DataIn;
            req.op    <= Wr ? OP_WR : OP_RD;
            req.hit   <= lookup_hit;
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= WAIT;
            stall_q   <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state   <= DONE;
            stall_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          stall_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign store_we = done_q & (req.op == OP_WR);

  resp_backing_store #(
    .MEM_ID (MEM_ID),
    .MEM_AW (MEM_AW)
  ) u_store (
    .clk        (clk),
    .we         (store_we),
    .addr       (req.waddr[MEM_AW-1:0]),
    .wdata      (req.data),
    .createdump (createdump),
    .rdata      (store_rdata)
  );

  // Output decode: the zero-cycle hit path and err must be combinational,
  // the slow-path completion comes from registered flags.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    DataOut  = '0;
    Done     = done_q | rd_hit;
    Stall    = stall_q;
    CacheHit = (done_q & req.hit) | rd_hit;
    err      = (state == IDLE) & bad_req;
    if (rd_hit) begin
      DataOut = line_data;
    end else if (done_q && req.op == OP_RD) begin
      DataOut = store_rdata;
    end
  end

endmodule

// File: tb/tb_cache_responder.sv
// Self-checking bench for cache_responder (LINES=16, LATENCY=4).
// Preloads the used store words with w ^ 16'hA5A5 through protocol writes,
// then runs the hit/miss/write-through/err/reset-abort sequences. Expected
// results go into a scoreboard queue when a request is driven and are popped
// when Done appears. Hit expectations follow CACHE_RESP_EN.
module tb_cache_responder;

  localparam int LATENCY = 4;
`ifdef CACHE_RESP_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] Addr = '0;
  logic [15:0] DataIn = '0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic        createdump = 1'b0;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic        is_rd;
    logic [15:0] data;
    logic        hit;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  logic [15:0] model_mem [int];

  cache_responder #(
    .MEM_ID  (0),
    .LINES   (16),
    .LATENCY (LATENCY),
    .MEM_AW  (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Addr       (Addr),
    .DataIn     (DataIn),
    .Rd         (Rd),
    .Wr         (Wr),
    .createdump (createdump),
    .DataOut    (DataOut),
    .Done       (Done),
    .Stall      (Stall),
    .CacheHit   (CacheHit),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] store_word(input logic [15:0] addr);
    int w;
    w = int'(addr[15:1]);
    if (model_mem.exists(w)) return model_mem[w];
    return 16'(w) ^ 16'hA5A5;
  endfunction

  // Drive one Rd or Wr, hold it until Done (bounded), then score the result.
  task automatic run_access(input string name, input logic is_wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic spec_hit);
    exp_t e;
    exp_t got_e;
    int   stalls;
    int   cycles;
    e.name   = name;
    e.is_rd  = !is_wr;
    e.data   = is_wr ? 16'h0 : store_word(addr);
    e.hit    = spec_hit & CACHE_ON;
    e.stalls = (!is_wr && e.hit) ? 0 : LATENCY;
    exp_q.push_back(e);
    if (is_wr) model_mem[int'(addr[15:1])] = wdata;

    @(negedge clk);
    Rd = !is_wr;
    Wr = is_wr;
    Addr = addr;
    DataIn = wdata;
    stalls = 0;
    cycles = 0;
    #1;
    check({name, " err"}, 32'(err), 32'h0);
    while (!Done && cycles < 20) begin
      if (Stall) stalls++;
      @(negedge clk);
      #1;
      cycles++;
    end
    if (!Done) begin
      check({name, " done timeout"}, 32'(Done), 32'h1);
      void'(exp_q.pop_front());
    end else begin
      got_e = exp_q.pop_front();
      check({got_e.name, " stall cycles"}, 32'(stalls), 32'(got_e.stalls));
      check({got_e.name, " latency"}, 32'(cycles), 32'(got_e.stalls == 0 ? 0 : got_e.stalls + 1));
      check({got_e.name, " stall at done"}, 32'(Stall), 32'h0);
      check({got_e.name, " hit"}, 32'(CacheHit), 32'(got_e.hit));
      if (got_e.is_rd) check({got_e.name, " data"}, 32'(DataOut), 32'(got_e.data));
    end
    @(negedge clk);
    Rd = 1'b0;
    Wr = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] pre_addrs [5];
    pre_addrs = '{16'h0010, 16'h0030, 16'h0020, 16'h0040, 16'h0050};

    rst = 1'b1;
    #1;
    check("reset DataOut", 32'(DataOut), 32'h0);
    check("reset Done", 32'(Done), 32'h0);
    check("reset Stall", 32'(Stall), 32'h0);
    check("reset CacheHit", 32'(CacheHit), 32'h0);
    check("reset err", 32'(err), 32'h0);
    pulse_reset();

    // Preload used words with w ^ A5A5; store is not reset, cache is empty.
    foreach (pre_addrs[i]) begin
      run_access("preload", 1'b1, pre_addrs[i], 16'(pre_addrs[i] >> 1) ^ 16'hA5A5, 1'b0);
    end
    model_mem.delete();
    pulse_reset();

    // 1: cold read miss.
    run_access("t1 rd 0010 miss", 1'b0, 16'h0010, 16'h0, 1'b0);
    // 2: same address hits in zero cycles.
    run_access("t2 rd 0010 hit", 1'b0, 16'h0010, 16'h0, 1'b1);
    // 3: write hit updates both store and line.
    run_access("t3 wr 0010", 1'b1, 16'h0010, 16'hBEEF, 1'b1);
    run_access("t3 rd 0010 hit", 1'b0, 16'h0010, 16'h0, 1'b1);
    // 4: conflicting index evicts, original address then misses.
    run_access("t4 rd 0030 miss", 1'b0, 16'h0030, 16'h0, 1'b0);
    run_access("t4 rd 0010 miss", 1'b0, 16'h0010, 16'h0, 1'b0);

    // 5: malformed requests.
    @(negedge clk);
    Rd = 1'b1;
    Addr = 16'h0011;
    #1;
    check("t5 odd err", 32'(err), 32'h1);
    check("t5 odd Done", 32'(Done), 32'h0);
    check("t5 odd Stall", 32'(Stall), 32'h0);
    @(negedge clk);
    Rd = 1'b0;
    #1;
    check("t5 odd err clear", 32'(err), 32'h0);
    check("t5 odd not accepted", 32'(Stall), 32'h0);
    @(negedge clk);
    Rd = 1'b1;
    Wr = 1'b1;
    Addr = 16'h0020;
    DataIn = 16'hDEAD;
    #1;
    check("t5 rdwr err", 32'(err), 32'h1);
    check("t5 rdwr Done", 32'(Done), 32'h0);
    @(negedge clk);
    Rd = 1'b0;
    Wr = 1'b0;
    #1;
    check("t5 rdwr not accepted", 32'(Stall), 32'h0);
    run_access("t5 rd 0020 unchanged", 1'b0, 16'h0020, 16'h0, 1'b0);

    // 6: reset during the second WAIT cycle aborts a write.
    @(negedge clk);
    Wr = 1'b1;
    Addr = 16'h0040;
    DataIn = 16'h1234;
    @(negedge clk);
    #1;
    check("t6 wait1 Stall", 32'(Stall), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6 rst Stall", 32'(Stall), 32'h0);
    check("t6 rst Done", 32'(Done), 32'h0);
    check("t6 rst DataOut", 32'(DataOut), 32'h0);
    check("t6 rst CacheHit", 32'(CacheHit), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    Wr = 1'b0;
    #1;
    check("t6 post rst Done", 32'(Done), 32'h0);
    run_access("t6 rd 0040 miss", 1'b0, 16'h0040, 16'h0, 1'b0);

    // Extra: write miss does not allocate, later read still misses with new data.
    run_access("x wr 0050 miss", 1'b1, 16'h0050, 16'h5A5A, 1'b0);
    run_access("x rd 0050 miss", 1'b0, 16'h0050, 16'h0, 1'b0);
    run_access("x rd 0050 hit", 1'b0, 16'h0050, 16'h0, 1'b1);

    check("scoreboard empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
